usb_rx_packet_sequencer: RTL and testbench
==========================================

// Module: usb_rx_packet_sequencer
// PURPOSE
//  Sits behind the USB receiver controller; sequences each received packet from its byte strobes.
//  Validates the PID, buffers the DATA0/DATA1 payload and strips the 2 CRC16 bytes.
//  Commits the payload downstream (miner work loader) only for a good, non-duplicate packet.
//  Requests ACK/NAK handshakes from the USB transmitter; tracks the data toggle.
// PARAMETERS
//  MAX_PAYLOAD  64  max payload bytes per packet, excluding CRC16; buffer depth = MAX_PAYLOAD+2
// PORTS
//  clk           in   1  system clock
//  n_rst         in   1  asynchronous, active-low reset
//  receiving     in   1  high for the duration of a packet, from the USB receiver controller
//  write_enable  in   1  1-cycle strobe: rx_data holds a new byte (first strobe in a packet = PID)
//  rx_data       in   8  received byte
//  rcv_error     in   1  receiver error flag, sampled every cycle while receiving=1
//  toggle_clr    in   1  pulse: expected toggle <- DATA0
//  pay_ready     in   1  downstream ready
//  pay_valid     out  1  payload byte valid
//  pay_data      out  8  payload byte
//  pay_last      out  1  qualifies the final payload byte of a packet
//  hs_req        out  1  handshake request; level, held until hs_ack
//  hs_pid        out  4  requested handshake PID: ACK=4'b0010, NAK=4'b1010
//  hs_ack        in   1  pulse from transmitter: request consumed
//  pkt_err       out  1  1-cycle pulse: packet discarded (PID/CRC/overflow/short/rcv_error)
//  busy          out  1  state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, expected toggle=DATA0, pointers=0.
//  Reset outputs: pay_valid=0, pay_last=0, pay_data=0, hs_req=0, hs_pid=0, pkt_err=0, busy=0.
//  Reset mid-packet or mid-drain: abandon all work; no output pulse.
//  Packet end = falling edge of receiving (registered compare). Sticky err_f = rcv_error seen in packet.
//  States:
//   IDLE: receiving rise -> GET_PID.
//   GET_PID: on the first strobe, PID ok iff rx_data[7:4]==~rx_data[3:0].
//    Bad PID -> DISCARD with err_f=1.
//    Nibble 4'b0011 (DATA0) or 4'b1011 (DATA1) -> DATA; latch the toggle bit.
//    Any other good PID -> DISCARD, no handshake, no pkt_err.
//    End of packet before any strobe -> IDLE, no pulse.
//   DATA: each strobe writes buf[wr_ptr], then wr_ptr++.
//    Strobe with wr_ptr==MAX_PAYLOAD+2 -> no write, ovf_f=1.
//    On packet end -> EVAL.
//   EVAL (1 cycle): bad = err_f | ovf_f | (wr_ptr<2).
//    bad: pkt_err pulse, no handshake -> IDLE.
//    Toggle != expected (duplicate): ACK, no drain -> IDLE.
//    Otherwise: ACK, flip expected toggle, len=wr_ptr-2.
//     len==0 -> IDLE; else -> DRAIN.
//   DISCARD: ignore strobes until packet end. err_f -> pkt_err pulse. Then -> IDLE.
//   DRAIN: rd_ptr 0..len-1.
//    pay_valid rises the cycle after entry.
//    pay_data/pay_last held stable while pay_valid & !pay_ready.
//    One byte per cycle when pay_ready=1.
//    pay_last on byte len-1; after its transfer -> IDLE.
//  Packet arriving during DRAIN: not stored; tracked by a side flag (good DATA PID, no rcv_error).
//   At its end: NAK if the flag is set, else nothing. Toggle unchanged.
//  Handshake: hs_req set with hs_pid, cleared the cycle after hs_ack.
//   A new handshake while hs_req=1 is dropped; the host retries.
//  toggle_clr has priority over a same-cycle EVAL flip.
//  strobe and packet end in the same cycle: the byte is written first.
// STRUCTURE
//  usb_pkg: PID nibble constants (DATA0/DATA1/ACK/NAK), state enum typedef.
//  Sub-module usb_rx_payload_buf: 1W/1R synchronous RAM.
//   Depth MAX_PAYLOAD+2, 8-bit, 1-cycle read latency.
//  Top-level block: FSM, pointers, flags, output skid register.
// TESTING
//  DATA0 C3,11,22,33,crcL,crcH; expected DATA0; pay_ready=1.
//   -> ACK; 11,22,33 drained, pay_last on 33; expected toggle -> DATA1.
//  Same packet repeated (toggle now DATA1) -> ACK only, no pay_valid, toggle stays DATA1.
//  rcv_error pulsed mid-payload -> pkt_err 1 pulse, hs_req stays 0, no payload.
//  PID 8'hC4 (nibbles not complementary) -> pkt_err, no handshake.
//  MAX_PAYLOAD+3 bytes -> pkt_err, no handshake.
//  Drain with pay_ready toggling 1/0 every cycle -> bytes in order, none lost or duplicated.
//  DATA1 packet arriving mid-DRAIN -> NAK after its end; first packet still fully drained.
//  Hold hs_ack=0 while 2 packets complete -> second handshake dropped, hs_pid unchanged.
//  n_rst asserted mid-DRAIN -> all outputs 0; next DATA0 accepted as new.

Source files
------------

// File: rtl/usb_rx_packet_sequencer_pkg.sv
// Shared definitions for the USB receive packet sequencer: PID nibbles, FSM states
// and PID classification helpers.
package usb_rx_packet_sequencer_pkg;

    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_PID,
        ST_DATA,
        ST_EVAL,
        ST_DISCARD,
        ST_DRAIN
    } state_t;

    // A PID byte carries its type nibble and the complement of it in the high half.
    function automatic logic pid_ok(input logic [7:0] pid);
        return pid[7:4] == ~pid[3:0];
    endfunction

    function automatic logic pid_is_data(input logic [3:0] nib);
        return (nib == PID_DATA0) || (nib == PID_DATA1);
    endfunction

endpackage

// File: rtl/usb_rx_payload_buf.sv
// Single-write, single-read synchronous payload RAM with a one-cycle read latency.
// The read register only updates on rd_en, so it holds its byte while the reader stalls.
module usb_rx_payload_buf #(
    parameter int DEPTH = 66,
    parameter int AW    = 7
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/usb_rx_packet_sequencer.sv
// Sequences received USB packets: PID check, payload buffering with CRC16 strip,
// duplicate detection via data toggle, ACK/NAK requests and payload drain.
module usb_rx_packet_sequencer
    import usb_rx_packet_sequencer_pkg::*;
#(
    parameter int MAX_PAYLOAD = 64
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       receiving,
    input  logic       write_enable,
    input  logic [7:0] rx_data,
    input  logic       rcv_error,
    input  logic       toggle_clr,
    input  logic       pay_ready,
    output logic       pay_valid,
    output logic [7:0] pay_data,
    output logic       pay_last,
    output logic       hs_req,
    output logic [3:0] hs_pid,
    input  logic       hs_ack,
    output logic       pkt_err,
    output logic       busy
);

    localparam int DEPTH = MAX_PAYLOAD + 2;
    localparam int PW    = $clog2(DEPTH + 1);

    state_t        state, state_n;
    logic          rcv_q;
    logic          rise, pkt_end;
    logic          err_f, ovf_f;
    logic          rx_tog, exp_tog;
    logic [PW-1:0] wr_ptr, rd_ptr, len, len_calc, len_cur;
    logic          bad;

    logic          err_set, tog_load, pkt_err_n, eval_ack, flip, drain_start;
    logic          hs_new;
    logic [3:0]    hs_new_pid;

    logic          side_act, side_pid_seen, side_ok, side_err, side_nak;

    logic          buf_wr, buf_rd;
    logic [7:0]    buf_rdata;
    logic          m_v, m_last, load_out;

    assign rise     = receiving & ~rcv_q;
    assign pkt_end  = rcv_q & ~receiving;
    assign len_calc = wr_ptr - PW'(2);
    assign bad      = err_f | ovf_f | (wr_ptr < PW'(2));
    assign len_cur  = (state == ST_EVAL) ? len_calc : len;
    assign busy     = (state != ST_IDLE);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n     = state;
        err_set     = 1'b0;
        tog_load    = 1'b0;
        pkt_err_n   = 1'b0;
        eval_ack    = 1'b0;
        flip        = 1'b0;
        drain_start = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rise) state_n = ST_GET_PID;
            end
            ST_GET_PID: begin
                if (write_enable) begin
                    if (!pid_ok(rx_data)) begin
                        err_set = 1'b1;
                        if (pkt_end) begin
                            pkt_err_n = 1'b1;
                            state_n   = ST_IDLE;
                        end else begin
                            state_n = ST_DISCARD;
                        end
                    end else if (pid_is_data(rx_data[3:0])) begin
                        tog_load = 1'b1;
                        state_n  = pkt_end ? ST_EVAL : ST_DATA;
                    end else if (pkt_end) begin
                        pkt_err_n = err_f;
                        state_n   = ST_IDLE;
                    end else begin
                        state_n = ST_DISCARD;
                    end
                end else if (pkt_end) begin
                    state_n = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (pkt_end) state_n = ST_EVAL;
            end
            ST_EVAL: begin
                state_n = ST_IDLE;
                if (bad) begin
                    pkt_err_n = 1'b1;
                end else begin
                    eval_ack = 1'b1;
                    // A repeated toggle means the host missed our last ACK: acknowledge only.
                    if (rx_tog == exp_tog) begin
                        flip = 1'b1;
                        if (len_calc != '0) begin
                            drain_start = 1'b1;
                            state_n     = ST_DRAIN;
                        end
                    end
                end
            end
            ST_DISCARD: begin
                if (pkt_end) begin
                    pkt_err_n = err_f;
                    state_n   = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (pay_valid && pay_ready && pay_last) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign side_nak   = side_act & pkt_end & side_ok & ~side_err;
    assign hs_new     = eval_ack | side_nak;
    assign hs_new_pid = eval_ack ? PID_ACK : PID_NAK;

    assign buf_wr   = (state == ST_DATA) && write_enable && (wr_ptr != PW'(DEPTH));
    assign load_out = m_v & (~pay_valid | pay_ready);
    assign buf_rd   = drain_start ||
                      ((state == ST_DRAIN) && (rd_ptr != len) && (!m_v || load_out));

    usb_rx_payload_buf #(
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_buf (
        .clk     (clk),
        .wr_en   (buf_wr),
        .wr_addr (wr_ptr),
        .wr_data (rx_data),
        .rd_en   (buf_rd),
        .rd_addr (rd_ptr),
        .rd_data (buf_rdata)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rcv_q         <= 1'b0;
            err_f         <= 1'b0;
            ovf_f         <= 1'b0;
            rx_tog        <= 1'b0;
            exp_tog       <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            len           <= '0;
            pkt_err       <= 1'b0;
            hs_req        <= 1'b0;
            hs_pid        <= 4'b0000;
            side_act      <= 1'b0;
            side_pid_seen <= 1'b0;
            side_ok       <= 1'b0;
            side_err      <= 1'b0;
            m_v           <= 1'b0;
            m_last        <= 1'b0;
            pay_valid     <= 1'b0;
            pay_data      <= 8'h00;
            pay_last      <= 1'b0;
        end else begin
            rcv_q   <= receiving;
            pkt_err <= pkt_err_n;

            if (state == ST_IDLE) begin
                err_f <= receiving & rcv_error;
            end else if (err_set || (receiving && rcv_error)) begin
                err_f <= 1'b1;
            end

            if (tog_load) rx_tog <= rx_data[3];

            if (toggle_clr) begin
                exp_tog <= 1'b0;
            end else if (flip) begin
                exp_tog <= ~exp_tog;
            end

            if (state == ST_IDLE) begin
                wr_ptr <= '0;
                ovf_f  <= 1'b0;
            end else if ((state == ST_DATA) && write_enable) begin
                if (wr_ptr == PW'(DEPTH)) begin
                    ovf_f <= 1'b1;
                end else begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
            end

            if (state == ST_EVAL) len <= len_calc;

            // Same-cycle ack and new request: the clear wins and the request is lost.
            if (hs_req && hs_ack) begin
                hs_req <= 1'b0;
            end else if (!hs_req && hs_new) begin
                hs_req <= 1'b1;
                hs_pid <= hs_new_pid;
            end

            // A packet that shows up while draining is only watched, never stored.
            if ((state == ST_DRAIN) && rise) begin
                side_act      <= 1'b1;
                side_pid_seen <= 1'b0;
                side_ok       <= 1'b0;
                side_err      <= rcv_error;
            end else if (side_act) begin
                if (receiving && rcv_error) side_err <= 1'b1;
                if (write_enable && !side_pid_seen) begin
                    side_pid_seen <= 1'b1;
                    side_ok       <= pid_ok(rx_data) && pid_is_data(rx_data[3:0]);
                end
                if (pkt_end) side_act <= 1'b0;
            end

            // Fetch stage: m_v marks an unconsumed byte sitting in the RAM read register.
            if (buf_rd) begin
                rd_ptr <= rd_ptr + PW'(1);
                m_v    <= 1'b1;
                m_last <= ((rd_ptr + PW'(1)) == len_cur);
            end else begin
                if (load_out) m_v <= 1'b0;
                if (state == ST_IDLE) begin
                    rd_ptr <= '0;
                    m_v    <= 1'b0;
                end
            end

            if (load_out) begin
                pay_valid <= 1'b1;
                pay_data  <= buf_rdata;
                pay_last  <= m_last;
            end else if (pay_valid && pay_ready) begin
                pay_valid <= 1'b0;
                pay_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_usb_rx_packet_sequencer.sv
// Self-checking bench for usb_rx_packet_sequencer: directed scenarios plus random packets,
// compared against a packet-level reference model of accepted payload and handshakes.
module tb_usb_rx_packet_sequencer;

    localparam int MAX_PAYLOAD = 64;
    localparam int DEPTH       = MAX_PAYLOAD + 2;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       receiving = 1'b0;
    logic       write_enable = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rcv_error = 1'b0;
    logic       toggle_clr = 1'b0;
    logic       pay_ready = 1'b0;
    logic       pay_valid;
    logic [7:0] pay_data;
    logic       pay_last;
    logic       hs_req;
    logic [3:0] hs_pid;
    logic       hs_ack = 1'b0;
    logic       pkt_err;
    logic       busy;

    usb_rx_packet_sequencer #(
        .MAX_PAYLOAD (MAX_PAYLOAD)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .receiving    (receiving),
        .write_enable (write_enable),
        .rx_data      (rx_data),
        .rcv_error    (rcv_error),
        .toggle_clr   (toggle_clr),
        .pay_ready    (pay_ready),
        .pay_valid    (pay_valid),
        .pay_data     (pay_data),
        .pay_last     (pay_last),
        .hs_req       (hs_req),
        .hs_pid       (hs_pid),
        .hs_ack       (hs_ack),
        .pkt_err      (pkt_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [8:0] exp_q[$];
    logic [3:0] hs_q[$];
    int         exp_err_cnt = 0;
    int         act_err_cnt = 0;
    logic       model_tog = 1'b0;
    bit         hold_ack = 1'b0;
    bit         hs_held = 1'b0;
    int         ready_mode = 0;
    logic [7:0] pkt[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic void expect_hs(input logic [3:0] pid);
        if (hold_ack && hs_held) return;
        if (hold_ack) hs_held = 1'b1;
        hs_q.push_back(pid);
    endfunction

    function automatic void model_packet(input bit err, input bit side);
        int   n;
        logic tog;
        if (pkt.size() == 0) return;
        n = pkt.size() - 1;
        if (side) begin
            if ((pkt[0] == 8'hC3 || pkt[0] == 8'h4B) && !err) expect_hs(4'hA);
            return;
        end
        if (pkt[0][7:4] != ~pkt[0][3:0]) begin
            exp_err_cnt++;
            return;
        end
        if (pkt[0] != 8'hC3 && pkt[0] != 8'h4B) begin
            if (err) exp_err_cnt++;
            return;
        end
        if (err || n > DEPTH || n < 2) begin
            exp_err_cnt++;
            return;
        end
        expect_hs(4'h2);
        tog = (pkt[0] == 8'h4B);
        if (tog != model_tog) return;
        model_tog = ~model_tog;
        for (int i = 1; i <= n - 2; i++) exp_q.push_back({(i == n - 2), pkt[i]});
    endfunction

    // ---------------- compare process ----------------
    logic       hs_req_prev = 1'b0;
    logic       ack_prev = 1'b0;
    bit         stall_pending = 1'b0;
    logic [8:0] stall_word = 9'h0;

    always @(negedge clk) begin
        if (!n_rst) begin
            hs_req_prev   = 1'b0;
            ack_prev      = 1'b0;
            stall_pending = 1'b0;
        end else begin
            if (stall_pending) begin
                check("stall_valid", pay_valid, 1);
                check("stall_word", {pay_last, pay_data}, stall_word);
            end
            stall_pending = pay_valid && !pay_ready;
            stall_word    = {pay_last, pay_data};
            if (pay_valid && pay_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL payload_extra: got %0h expected no byte", {pay_last, pay_data});
                end else begin
                    check("payload", {pay_last, pay_data}, exp_q.pop_front());
                end
            end
            if (hs_req && !hs_req_prev) begin
                if (hs_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL hs_extra: got pid %0h expected no handshake", hs_pid);
                end else begin
                    check("hs_pid", hs_pid, hs_q.pop_front());
                end
            end
            if (ack_prev) check("hs_clear_after_ack", hs_req, 0);
            if (pkt_err) act_err_cnt++;
            hs_req_prev = hs_req;
            ack_prev    = hs_ack;
        end
    end

    // ---------------- background drivers ----------------
    initial begin
        forever begin
            tick;
            if (hs_req && !hold_ack && n_rst) begin
                repeat ($urandom_range(0, 3)) tick;
                hs_ack = 1'b1;
                tick;
                hs_ack = 1'b0;
            end
        end
    end

    bit ready_phase = 1'b0;
    initial begin
        forever begin
            tick;
            ready_phase = ~ready_phase;
            case (ready_mode)
                0: pay_ready = 1'b1;
                1: pay_ready = ready_phase;
                2: pay_ready = ($urandom_range(0, 3) == 0);
                default: pay_ready = $urandom_range(0, 1) == 1;
            endcase
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus tasks ----------------
    task automatic send_packet(input int err_at);
        receiving = 1'b1;
        repeat (2) tick;
        for (int i = 0; i < pkt.size(); i++) begin
            write_enable = 1'b1;
            rx_data      = pkt[i];
            rcv_error    = (i == err_at);
            tick;
            write_enable = 1'b0;
            rcv_error    = 1'b0;
            repeat ($urandom_range(0, 2)) tick;
        end
        receiving = 1'b0;
        tick;
    endtask

    task automatic fill_packet(input logic [7:0] pid, input int n);
        pkt.delete();
        pkt.push_back(pid);
        for (int i = 0; i < n; i++) pkt.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic wait_idle(input string tag);
        int cnt = 0;
        while ((busy || (hs_req && !hold_ack)) && cnt < 3000) begin
            tick;
            cnt++;
        end
        if (cnt >= 3000) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got busy=%0d hs_req=%0d expected idle", tag, busy, hs_req);
        end
        repeat (4) tick;
        check({tag, "_pkt_err_count"}, act_err_cnt, exp_err_cnt);
        check({tag, "_payload_left"}, exp_q.size(), 0);
        check({tag, "_hs_left"}, hs_q.size(), 0);
    endtask

    task automatic wait_pay_valid(input string tag);
        int cnt = 0;
        while (!pay_valid && cnt < 200) begin
            tick;
            cnt++;
        end
        if (cnt >= 200) begin
            checks++;
            errors++;
            $display("FAIL %s_no_drain: got pay_valid=0 expected 1", tag);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_pay_valid"}, pay_valid, 0);
        check({tag, "_pay_last"}, pay_last, 0);
        check({tag, "_pay_data"}, pay_data, 0);
        check({tag, "_hs_req"}, hs_req, 0);
        check({tag, "_hs_pid"}, hs_pid, 0);
        check({tag, "_pkt_err"}, pkt_err, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int err_at;
        int kind;
        int n;
        logic [3:0] nib;
        logic [3:0] hi;
        logic [3:0] others[8];
        others = '{4'h1, 4'h9, 4'h5, 4'hD, 4'h2, 4'hA, 4'hE, 4'h6};

        n_rst = 1'b0;
        repeat (3) tick;
        check_outputs_zero("reset");
        n_rst = 1'b1;
        repeat (2) tick;

        // good DATA0 with three payload bytes
        ready_mode = 0;
        pkt = '{8'hC3, 8'h11, 8'h22, 8'h33, 8'hA5, 8'h5A};
        model_packet(1'b0, 1'b0);
        check("pin_first_len", exp_q.size(), 3);
        check("pin_first_byte", exp_q[0], 9'h011);
        check("pin_first_last", exp_q[2], 9'h133);
        check("pin_first_hs", hs_q[0], 4'h2);
        check("pin_first_tog", model_tog, 1);
        send_packet(-1);
        wait_idle("data0_first");

        // identical packet again: duplicate, ACK only
        model_packet(1'b0, 1'b0);
        check("pin_dup_len", exp_q.size(), 0);
        check("pin_dup_tog", model_tog, 1);
        send_packet(-1);
        wait_idle("duplicate");

        // rcv_error in the middle of the payload
        fill_packet(8'h4B, 5);
        model_packet(1'b1, 1'b0);
        check("pin_rcv_err", exp_err_cnt, 1);
        send_packet(3);
        wait_idle("rcv_error");

        // non-complementary PID
        pkt = '{8'hC4, 8'h01, 8'h02, 8'h03};
        model_packet(1'b0, 1'b0);
        check("pin_bad_pid", exp_err_cnt, 2);
        send_packet(-1);
        wait_idle("bad_pid");

        // one byte past the buffer depth
        fill_packet(8'h4B, MAX_PAYLOAD + 3);
        model_packet(1'b0, 1'b0);
        check("pin_overflow", exp_err_cnt, 3);
        send_packet(-1);
        wait_idle("overflow");

        // maximum payload fits exactly
        fill_packet(8'h4B, MAX_PAYLOAD + 2);
        model_packet(1'b0, 1'b0);
        check("pin_max_len", exp_q.size(), MAX_PAYLOAD);
        send_packet(-1);
        wait_idle("max_payload");

        // drain with pay_ready toggling every cycle
        ready_mode = 1;
        fill_packet(8'hC3, 10);
        model_packet(1'b0, 1'b0);
        send_packet(-1);
        wait_idle("ready_toggle");

        // DATA1 arriving while the previous payload is still draining
        ready_mode = 2;
        fill_packet(8'h4B, 22);
        model_packet(1'b0, 1'b0);
        send_packet(-1);
        wait_pay_valid("mid_drain");
        fill_packet(8'h4B, 5);
        model_packet(1'b0, 1'b1);
        check("pin_side_nak", hs_q[hs_q.size()-1], 4'hA);
        send_packet(-1);
        check("side_still_draining", busy, 1);
        wait_idle("mid_drain");

        // handshake held: second request is dropped
        ready_mode = 0;
        hold_ack = 1'b1;
        hs_held  = 1'b0;
        fill_packet(8'hC3, 4);
        model_packet(1'b0, 1'b0);
        send_packet(-1);
        wait_idle("hold_first");
        fill_packet(8'h4B, 5);
        model_packet(1'b0, 1'b0);
        send_packet(-1);
        wait_idle("hold_second");
        check("hold_hs_req", hs_req, 1);
        check("hold_hs_pid", hs_pid, 4'h2);
        hold_ack = 1'b0;
        hs_held  = 1'b0;
        wait_idle("hold_release");

        // reset in the middle of a drain
        ready_mode = 2;
        fill_packet(8'hC3, 20);
        model_packet(1'b0, 1'b0);
        send_packet(-1);
        wait_pay_valid("reset_drain");
        n_rst = 1'b0;
        tick;
        check_outputs_zero("mid_reset");
        exp_q.delete();
        hs_q.delete();
        model_tog = 1'b0;
        repeat (3) tick;
        n_rst = 1'b1;
        repeat (2) tick;
        ready_mode = 0;
        fill_packet(8'hC3, 4);
        model_packet(1'b0, 1'b0);
        check("pin_after_reset", exp_q.size(), 2);
        send_packet(-1);
        wait_idle("after_reset");

        // toggle_clr forces DATA0 as the expected toggle
        toggle_clr = 1'b1;
        tick;
        toggle_clr = 1'b0;
        model_tog  = 1'b0;
        fill_packet(8'hC3, 3);
        model_packet(1'b0, 1'b0);
        send_packet(-1);
        wait_idle("toggle_clr");

        // random packets
        for (int p = 0; p < 30; p++) begin
            ready_mode = $urandom_range(0, 3);
            kind = $urandom_range(0, 9);
            n = $urandom_range(0, 8);
            if (kind <= 5) begin
                fill_packet(($urandom_range(0, 1) == 1) ? 8'h4B : 8'hC3, n);
            end else if (kind == 6) begin
                nib = 4'($urandom_range(0, 15));
                hi  = 4'($urandom_range(0, 15));
                if (hi == ~nib) hi = hi ^ 4'h1;
                fill_packet({hi, nib}, n);
            end else if (kind == 7) begin
                nib = others[$urandom_range(0, 7)];
                fill_packet({~nib, nib}, n);
            end else if (kind == 8) begin
                pkt.delete();
            end else begin
                fill_packet(($urandom_range(0, 1) == 1) ? 8'h4B : 8'hC3,
                            $urandom_range(DEPTH - 1, DEPTH + 2));
            end
            err_at = -1;
            if (pkt.size() > 0 && $urandom_range(0, 4) == 0) err_at = $urandom_range(0, pkt.size() - 1);
            model_packet(err_at >= 0, 1'b0);
            send_packet(err_at);
            wait_idle("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
